mac_vert_column_scheduler: RTL

Sequences one vertical bit-serial MAC unit through a single dot-product job.
- Accepts weight bit-columns from an upstream column buffer over a valid/ready stream.
- Issues one column per cycle to the MAC, MSB first, driving mac_en, is_msb, column_idx, act_sel and is_skip_zero.
- Inserts one drain cycle to flush the MAC's 2-stage accumulate pipeline, then presents a result handshake to the writeback/pooling stage.
- Sits between the weight-column fetch logic and the MAC array row.

---
 rtl/mac_vert_column_scheduler.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mac_vert_column_scheduler.sv
// rtl/mac_vert_column_scheduler.sv - sequences one vertical bit-serial MAC through a dot-product job, MSB column first.
// Optional stall counter output enabled by defining MAC_SCHED_PERF_CNT_EN.
module mac_vert_column_scheduler #(
    parameter int DATA_WIDTH    = 8,
    parameter int VEC_LENGTH    = 16,
    parameter int MUX_SEL_WIDTH = $clog2(VEC_LENGTH) + 1,
    parameter int COL_IDX_WIDTH = $clog2(DATA_WIDTH),
    parameter int ZERO_SEL      = 0
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         start,
    input  logic [COL_IDX_WIDTH:0]                       cfg_num_cols,
    input  logic                                         cfg_pooling,
    output logic                                         busy,
    input  logic                                         col_valid,
    output logic                                         col_ready,
    input  logic [(VEC_LENGTH/2)*(MUX_SEL_WIDTH-1)-1:0]  col_sel,
    input  logic [(VEC_LENGTH/8)-1:0]                    col_skip_zero,
    output logic                                         mac_en,
    output logic                                         mac_is_msb,
    output logic [COL_IDX_WIDTH-1:0]                     mac_column_idx,
    output logic [(VEC_LENGTH/2)*(MUX_SEL_WIDTH-1)-1:0]  mac_act_sel,
    output logic [(VEC_LENGTH/8)-1:0]                    mac_is_skip_zero,
    output logic                                         mac_is_pooling,
`ifdef MAC_SCHED_PERF_CNT_EN
    output logic [15:0]                                  stall_cnt,
`endif
    output logic                                         res_valid,
    input  logic                                         res_ready
);

    localparam int SEL_W  = MUX_SEL_WIDTH - 1;
    localparam int N_ADD  = VEC_LENGTH / 2;
    localparam int N_GRP  = VEC_LENGTH / 8;
    localparam int CNT_W  = COL_IDX_WIDTH + 1;
    localparam logic [CNT_W-1:0] MAX_COLS   = CNT_W'(DATA_WIDTH);
    localparam logic [SEL_W-1:0] ZERO_SEL_L = SEL_W'(ZERO_SEL);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        RESULT = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic               first_q, first_d;
    logic               pooling_q, pooling_d;
    logic               busy_q, busy_d;
    logic               col_ready_q, col_ready_d;
    logic               res_valid_q, res_valid_d;
    logic               issue;
`ifdef MAC_SCHED_PERF_CNT_EN
    logic [15:0]        stall_cnt_q, stall_cnt_d;
`endif

    assign issue = (state_q == RUN) && col_valid;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        first_d     = first_q;
        pooling_d   = pooling_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    remaining_d = ((cfg_num_cols == '0) || (cfg_num_cols > MAX_COLS))
                                  ? MAX_COLS : cfg_num_cols;
                    first_d     = 1'b1;
                    pooling_d   = cfg_pooling;
                    state_d     = RUN;
                end
            end
            RUN: begin
                if (issue) begin
                    remaining_d = remaining_q - CNT_W'(1);
                    first_d     = 1'b0;
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_d = RESULT;
            end
            RESULT: begin
                if (res_ready) begin
                    state_d   = IDLE;
                    pooling_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d      = (state_d != IDLE);
        col_ready_d = (state_d == RUN);
        res_valid_d = (state_d == RESULT);
    end

`ifdef MAC_SCHED_PERF_CNT_EN
    // Saturating count of cycles lost to an empty column stream or a stalled consumer.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == IDLE) && start) begin
            stall_cnt_d = '0;
        end else if ((((state_q == RUN) && !col_valid) || ((state_q == RESULT) && !res_ready))
                     && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            first_q     <= 1'b0;
            pooling_q   <= 1'b0;
            busy_q      <= 1'b0;
            col_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
`ifdef MAC_SCHED_PERF_CNT_EN
            stall_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            first_q     <= first_d;
            pooling_q   <= pooling_d;
            busy_q      <= busy_d;
            col_ready_q <= col_ready_d;
            res_valid_q <= res_valid_d;
`ifdef MAC_SCHED_PERF_CNT_EN
            stall_cnt_q <= stall_cnt_d;
`endif
        end
    end

    // Column fields pass straight through on an issue; the drain cycle feeds zeros to flush the pipeline.
    always_comb begin
        for (int i = 0; i < N_ADD; i++) begin
            mac_act_sel[i*SEL_W +: SEL_W] = ZERO_SEL_L;
        end
        mac_is_skip_zero = '0;
        mac_column_idx   = '0;
        if (issue) begin
            mac_act_sel      = col_sel;
            mac_is_skip_zero = col_skip_zero;
            mac_column_idx   = COL_IDX_WIDTH'(remaining_q - CNT_W'(1));
        end else if (state_q == DRAIN) begin
            mac_is_skip_zero = {N_GRP{1'b1}};
        end
    end

    assign mac_en         = issue || (state_q == DRAIN);
    assign mac_is_msb     = issue && first_q;
    assign mac_is_pooling = pooling_q;
    assign busy           = busy_q;
    assign col_ready      = col_ready_q;
    assign res_valid      = res_valid_q;

endmodule
